// File: rtl/wb_pkg.sv
// Shared Wishbone widths and arbiter state encoding for the two-master arbiter.
package wb_pkg;

  localparam int DW = 32;
  localparam int SW = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  // Index of the master that wins a simultaneous request: whoever did not own the bus last.
  function automatic logic tie_winner(input logic last_owner);
    return ~last_owner;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall counter for a granted strobe; expired is high while the count sits at TIMEOUT.
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // clear wins over count_en so the terminal count lasts exactly one cycle
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with fair tie-break, no preemption and a stalled-strobe watchdog.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [SW-1:0] s_sel_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  output logic [1:0]    fsm_state
);

  // Handshake: a transfer is offered while cyc and stb are high and completes in the
  // cycle ack (or err) is high; the owner keeps cyc high across back-to-back strobes.

  logic [1:0] state, state_next;
  logic       last_owner, last_owner_next;
  logic       grant0, grant1;
  logic       m_cyc, m_stb;
  logic       expired, timeout_hit, count_en, wd_clear;

  assign grant0 = reset_n && (state == ST_GRANT0);
  assign grant1 = reset_n && (state == ST_GRANT1);
  assign m_cyc  = (grant0 & m0_cyc_i) | (grant1 & m1_cyc_i);
  assign m_stb  = (grant0 & m0_stb_i) | (grant1 & m1_stb_i);

  assign count_en    = m_cyc & m_stb & ~s_ack_i & ~s_err_i;
  assign wd_clear    = ~count_en | expired;
  assign timeout_hit = m_cyc & expired & ~s_ack_i;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (wd_clear),
    .count_en (count_en),
    .expired  (expired)
  );

  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    case (state)
      ST_IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || tie_winner(last_owner) == 1'b0)) begin
          state_next      = ST_GRANT0;
          last_owner_next = 1'b0;
        end else if (m1_cyc_i) begin
          state_next      = ST_GRANT1;
          last_owner_next = 1'b1;
        end
      end
      ST_GRANT0: if (!m0_cyc_i) state_next = ST_IDLE;
      ST_GRANT1: if (!m1_cyc_i) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (grant0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i & ~timeout_hit;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_sel_o = m0_sel_i;
      s_dat_o = m0_dat_i;
    end else if (grant1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i & ~timeout_hit;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_sel_o = m1_sel_i;
      s_dat_o = m1_dat_i;
    end
  end

  // Terminations are gated by the owner's cyc so a late slave ack is dropped.
  assign m0_ack_o = grant0 & m0_cyc_i & s_ack_i;
  assign m0_err_o = grant0 & m0_cyc_i & (s_err_i | timeout_hit);
  assign m1_ack_o = grant1 & m1_cyc_i & s_ack_i;
  assign m1_err_o = grant1 & m1_cyc_i & (s_err_i | timeout_hit);

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign fsm_state = state;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed arbitration/watchdog scenarios plus random traffic against an owner/stall model.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int TMO = 8;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
  logic [31:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(TMO), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .fsm_state(fsm_state)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: who owns the bus, who owned it last, how long the current strobe has stalled.
  int own   = -1;
  int last  = 1;
  int stall = 0;

  // Bench slave: acks slave_lat cycles after it first sees a strobe.
  bit auto_slave = 1'b0;
  int slave_lat  = 2;
  int sl_cnt     = 0;

  logic obs_cyc, obs_stb, obs_ack0, obs_ack1, obs_err0, obs_err1;
  logic [1:0] exp_q[$];
  bit sb_on = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic rand_payload();
    m0_we_i  = 1'($urandom_range(0, 1));
    m1_we_i  = 1'($urandom_range(0, 1));
    m0_adr_i = AW'($urandom);
    m1_adr_i = AW'($urandom);
    m0_sel_i = 4'($urandom_range(0, 15));
    m1_sel_i = 4'($urandom_range(0, 15));
    m0_dat_i = $urandom;
    m1_dat_i = $urandom;
  endtask

  // One clock: inputs already driven; compare at negedge, advance model at posedge.
  task automatic tick();
    logic          mc, ms, tmo, ak, er, wev;
    logic [2:0]    e_ctl;
    logic [AW-1:0] e_adr;
    logic [3:0]    e_sel, e_term;
    logic [31:0]   e_dat;
    logic [1:0]    exp_id, got_id;
    if (auto_slave) begin
      s_ack_i = (sl_cnt == slave_lat);
      s_err_i = 1'b0;
    end
    s_dat_i = $urandom;
    @(negedge clk);
    mc = 1'b0; ms = 1'b0; tmo = 1'b0; ak = 1'b0; er = 1'b0; wev = 1'b0;
    e_ctl = '0; e_adr = '0; e_sel = '0; e_dat = '0; e_term = '0;
    if (own >= 0) begin
      mc    = (own == 0) ? m0_cyc_i : m1_cyc_i;
      ms    = (own == 0) ? m0_stb_i : m1_stb_i;
      wev   = (own == 0) ? m0_we_i  : m1_we_i;
      tmo   = (stall == TMO) && mc && !s_ack_i;
      e_ctl = {mc, ms && !tmo, wev};
      e_adr = (own == 0) ? m0_adr_i : m1_adr_i;
      e_sel = (own == 0) ? m0_sel_i : m1_sel_i;
      e_dat = (own == 0) ? m0_dat_i : m1_dat_i;
      ak    = mc && s_ack_i;
      er    = mc && (s_err_i || tmo);
      e_term = (own == 0) ? {ak, er, 2'b00} : {2'b00, ak, er};
    end
    if (reset_n) begin
      check("s_ctl",  64'({s_cyc_o, s_stb_o, s_we_o}), 64'(e_ctl));
      check("s_adr",  64'(s_adr_o), 64'(e_adr));
      check("s_sel",  64'(s_sel_o), 64'(e_sel));
      check("s_dat",  64'(s_dat_o), 64'(e_dat));
      check("m_term", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'(e_term));
      check("m_dat",  {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
    end
    obs_cyc = s_cyc_o; obs_stb = s_stb_o;
    obs_ack0 = m0_ack_o; obs_ack1 = m1_ack_o; obs_err0 = m0_err_o; obs_err1 = m1_err_o;
    if (sb_on && (m0_ack_o || m1_ack_o)) begin
      got_id = m1_ack_o ? 2'd1 : 2'd0;
      exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 2'd3;
      check("ack_order", 64'(got_id), 64'(exp_id));
    end
    @(posedge clk);
    if (!reset_n) begin
      own = -1; last = 1; stall = 0; sl_cnt = 0;
    end else begin
      if (own < 0) begin
        if (m0_cyc_i && (!m1_cyc_i || last == 1)) begin
          own = 0; last = 0; stall = 0;
        end else if (m1_cyc_i) begin
          own = 1; last = 1; stall = 0;
        end
      end else if (!mc) begin
        own = -1; stall = 0;
      end else if (ms && !s_ack_i && !s_err_i && !tmo) begin
        stall++;
      end else begin
        stall = 0;
      end
      sl_cnt = (s_ack_i || !obs_stb) ? 0 : sl_cnt + 1;
    end
    #1;
  endtask

  task automatic masters_idle();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    masters_idle();
    rand_payload();
    s_ack_i = 1'b0; s_err_i = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
  endtask

  // Each master issues back-to-back strobes until it has collected n acks.
  task automatic traffic(input int n0, input int n1, output int ticks);
    int r0, r1;
    r0 = n0; r1 = n1; ticks = 0;
    while ((r0 > 0 || r1 > 0) && ticks < 300) begin
      m0_cyc_i = (r0 > 0); m0_stb_i = (r0 > 0);
      m1_cyc_i = (r1 > 0); m1_stb_i = (r1 > 0);
      rand_payload();
      tick();
      ticks++;
      if (obs_ack0) r0--;
      if (obs_ack1) r1--;
    end
    check("traffic_done", 64'(r0 + r1), 64'(0));
    masters_idle();
  endtask

  initial begin
    int t, k, ack_pct;
    bit seen_err, seen_ack;
    masters_idle();
    rand_payload();
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single read by m0: ack arrives 2 cycles after the strobe reaches the slave.
    auto_slave = 1'b1; slave_lat = 2;
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; rand_payload(); m0_we_i = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!obs_ack0 && k < 20);
    check("rd_latency", 64'(k), 64'(4));
    check("rd_m1_ack", 64'(obs_ack1), 64'(0));
    masters_idle(); tick();

    // Simultaneous request after reset: m0 first, one idle cycle, then m1.
    do_reset();
    sb_on = 1'b1; exp_q = '{2'd0, 2'd1};
    traffic(1, 1, t);
    check("tie_total", 64'(t), 64'(9));

    // Four back-to-back strobes for m0 all finish before m1 gets the bus.
    do_reset();
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    traffic(4, 2, t);
    check("b2b_total", 64'(t), 64'(21));
    check("sb_empty", 64'(exp_q.size()), 64'(0));
    sb_on = 1'b0;

    // Slave never answers: err pulses once, TIMEOUT cycles after the strobe, with stb low.
    auto_slave = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0;
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!obs_err0 && k < 30);
    check("tmo_latency", 64'(k), 64'(2 + TMO));
    check("tmo_stb", 64'(obs_stb), 64'(0));
    tick();
    check("tmo_pulse", 64'(obs_err0), 64'(0));
    masters_idle(); tick();

    // Ack landing on the terminal count is forwarded and no err is raised.
    auto_slave = 1'b1; slave_lat = TMO;
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    k = 0; seen_err = 1'b0; seen_ack = 1'b0;
    do begin
      tick(); k++;
      seen_err |= obs_err0; seen_ack |= obs_ack0;
    end while (!seen_ack && !seen_err && k < 30);
    check("race_ack_tick", 64'(k), 64'(2 + TMO));
    check("race_ack", 64'(seen_ack), 64'(1));
    check("race_err", 64'(seen_err), 64'(0));
    masters_idle(); tick();

    // Reset during an m1 strobe aborts it; the next tie goes to m0.
    auto_slave = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0;
    do_reset();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0; s_ack_i = 1'b1;
    tick();
    reset_n = 1'b1; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    check("rst_scyc", 64'(obs_cyc), 64'(0));
    check("rst_m1_ack", 64'({obs_ack1, obs_err1}), 64'(0));
    auto_slave = 1'b1; slave_lat = 2;
    sb_on = 1'b1; exp_q = '{2'd0, 2'd1};
    traffic(1, 1, t);
    check("rst_sb_empty", 64'(exp_q.size()), 64'(0));
    sb_on = 1'b0;

    // Random traffic with alternating responsive and silent slave phases.
    auto_slave = 1'b0; ack_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) ack_pct = ($urandom_range(0, 1) == 0) ? 0 : 30;
      if ($urandom_range(0, 7) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 7) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i && ($urandom_range(0, 7) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(0, 7) != 0);
      rand_payload();
      s_ack_i = ($urandom_range(0, 99) < ack_pct);
      s_err_i = (ack_pct != 0) && ($urandom_range(0, 31) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
